mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/class_len_lut.sv | 26 ++
 rtl/mc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer:
// exception cause codes, default per-class phase counts and the FSM state encoding.
package ctrl_pkg;

  localparam logic [4:0] CAUSE_INT     = 5'b00000;
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_RI      = 5'b01010;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  // Phase count per class, class 7 in the top nibble down to class 0 in the bottom.
  // class0=4, class1=2 (jr-like), class2=5, class3=3, class4=6, class5=0 (reserved),
  // class6=4, class7=3 (mul/div).
  localparam logic [8*4-1:0] DEF_CLASS_LEN = {4'd3, 4'd4, 4'd0, 4'd6,
                                              4'd3, 4'd5, 4'd2, 4'd4};

  // Only the mul/div class waits on the MDU by default.
  localparam logic [7:0] DEF_WAIT_MASK = 8'b1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXC  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/class_len_lut.sv
// Maps an instruction class to its phase count and flags classes that cannot
// be sequenced (out of range, fewer than two phases, or more phases than exist).
module class_len_lut
  import ctrl_pkg::*;
#(
  parameter int                      N_PHASES  = 6,
  parameter int                      N_CLASSES = 8,
  parameter int                      CLS_W     = 3,
  parameter logic [N_CLASSES*4-1:0]  CLASS_LEN = DEF_CLASS_LEN
) (
  input  logic [CLS_W-1:0] cls,
  output logic [3:0]       len,
  output logic             illegal
);

  // Table lookup with range and legality check.
  always_comb begin
    len     = 4'd0;
    illegal = 1'b1;
    if (int'(cls) < N_CLASSES) begin
      len     = CLASS_LEN[int'(cls)*4 +: 4];
      illegal = (len < 4'd2) || ({1'b0, len} > 5'(N_PHASES));
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through its
// per-class phase count, stalls mul/div classes on busy, counts retirements
// and diverts to a one-cycle exception state on reserved classes,
// synchronous exceptions or enabled interrupts.
module mc_sequencer
  import ctrl_pkg::*;
#(
  parameter int                     N_PHASES  = 6,
  parameter int                     N_CLASSES = 8,
  localparam int                    CLS_W     = $clog2(N_CLASSES),
  parameter logic [N_CLASSES*4-1:0] CLASS_LEN = DEF_CLASS_LEN,
  parameter logic [N_CLASSES-1:0]   WAIT_MASK = DEF_WAIT_MASK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CLS_W-1:0]    instr_class,
  input  logic                busy,
  input  logic                exc_req,
  input  logic [4:0]          exc_code,
  input  logic                irq,
  input  logic                irq_en,
  output logic [N_PHASES-1:0] phase,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                mdu_start,
  output logic                stall,
  output logic                last_phase,
  output logic                retire,
  output logic                exc_take,
  output logic [4:0]          exc_cause,
  output logic [31:0]         instr_cnt
);

  localparam int IDX_W = $clog2(N_PHASES);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [3:0]       len_q, len_d;
  logic             p2_seen_q, p2_seen_d;
  logic [4:0]       exc_cause_q, exc_cause_d;
  logic [31:0]      instr_cnt_q, instr_cnt_d;

  logic [3:0]       lut_len;
  logic             lut_illegal;
  logic             in_run, in_p0, in_p1, in_p2, wait_cls, hold, is_last;

  class_len_lut #(
    .N_PHASES  (N_PHASES),
    .N_CLASSES (N_CLASSES),
    .CLS_W     (CLS_W),
    .CLASS_LEN (CLASS_LEN)
  ) u_len_lut (
    .cls     (instr_class),
    .len     (lut_len),
    .illegal (lut_illegal)
  );

  // Phase status decode. In P1 the length is not registered yet, so whether P1
  // is the last phase comes from the live class lookup; from P2 on it comes
  // from the registered length. The first P2 cycle of a waiting class issues
  // the MDU operation and always holds; later P2 cycles hold while busy.
  always_comb begin
    in_run   = (state_q == ST_RUN);
    in_p0    = in_run && (idx_q == '0);
    in_p1    = in_run && (idx_q == IDX_W'(1));
    in_p2    = in_run && (idx_q == IDX_W'(2));
    wait_cls = WAIT_MASK[cls_q];
    hold     = in_p2 && wait_cls && (!p2_seen_q || busy);
    is_last  = (in_p1 && (lut_illegal || (lut_len == 4'd2))) ||
               (in_run && (idx_q >= IDX_W'(2)) &&
                (5'(idx_q) == ({1'b0, len_q} - 5'd1)));
  end

  // One-hot phase output, zero outside the running state.
  always_comb begin
    phase = '0;
    if (in_run) phase[idx_q] = 1'b1;
  end

  assign fetch_en   = in_p0;
  assign decode_en  = in_p0;
  assign mdu_start  = in_p2 && wait_cls && !p2_seen_q;
  assign stall      = in_p2 && wait_cls && p2_seen_q && busy;
  assign last_phase = is_last;
  assign retire     = is_last && !hold;
  assign exc_take   = (state_q == ST_EXC);
  assign exc_cause  = exc_cause_q;
  assign instr_cnt  = instr_cnt_q;

  // Next-state logic: phase stepping, retirement and exception selection.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cls_d       = cls_q;
    len_d       = len_q;
    p2_seen_d   = 1'b0;
    exc_cause_d = exc_cause_q;
    instr_cnt_d = instr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        idx_d   = '0;
      end
      ST_RUN: begin
        if (in_p1) begin
          cls_d = instr_class;
          len_d = lut_len;
        end
        p2_seen_d = hold;
        if (retire) begin
          instr_cnt_d = instr_cnt_q + 32'd1;
          idx_d       = '0;
          if (in_p1 && lut_illegal) begin
            state_d     = ST_EXC;
            exc_cause_d = CAUSE_RI;
          end else if (exc_req) begin
            state_d     = ST_EXC;
            exc_cause_d = exc_code;
          end else if (irq && irq_en) begin
            state_d     = ST_EXC;
            exc_cause_d = CAUSE_INT;
          end
        end else if (!hold) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_EXC: begin
        state_d = ST_RUN;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cls_q       <= '0;
      len_q       <= '0;
      p2_seen_q   <= 1'b0;
      exc_cause_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cls_q       <= cls_d;
      len_q       <= len_d;
      p2_seen_q   <= p2_seen_d;
      exc_cause_q <= exc_cause_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with default parameters
// (class lengths 4,2,5,3,6,0,4,3; class 7 waits on busy).
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst, busy, exc_req, irq, irq_en;
  logic [2:0]  instr_class;
  logic [4:0]  exc_code;
  logic [5:0]  phase;
  logic        fetch_en, decode_en, mdu_start, stall, last_phase, retire, exc_take;
  logic [4:0]  exc_cause;
  logic [31:0] instr_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_class (instr_class),
    .busy        (busy),
    .exc_req     (exc_req),
    .exc_code    (exc_code),
    .irq         (irq),
    .irq_en      (irq_en),
    .phase       (phase),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .mdu_start   (mdu_start),
    .stall       (stall),
    .last_phase  (last_phase),
    .retire      (retire),
    .exc_take    (exc_take),
    .exc_cause   (exc_cause),
    .instr_cnt   (instr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [49:0] all_outs();
    return {phase, fetch_en, decode_en, mdu_start, stall, last_phase, retire,
            exc_take, exc_cause, instr_cnt};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_start, n_stall, n_held, ret_k, start_k;
    rst = 1'b1; busy = 1'b0; exc_req = 1'b0; irq = 1'b0; irq_en = 1'b0;
    instr_class = 3'd0; exc_code = 5'd0;
    step(); step(); #1;
    chk("reset_outputs", 64'(all_outs()), 64'd0);

    // IDLE for one cycle, then P0.
    rst = 1'b0;
    step(); #1;
    chk("idle_to_p0_phase", 64'(phase), 64'h01);
    chk("idle_to_p0_fetch", 64'({fetch_en, decode_en}), 64'b11);

    // Class 0, L=4: phases 0,1,2,3,0; retire only in P3.
    instr_class = 3'd0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("l4_phase_k%0d", k), 64'(phase), (k < 4) ? (64'd1 << k) : 64'd1);
      chk($sformatf("l4_retire_k%0d", k), 64'(retire), (k == 3) ? 64'd1 : 64'd0);
      if (k < 4) begin step(); #1; end
    end
    chk("l4_cnt", 64'(instr_cnt), 64'd1);

    // Class 7 (waits on MDU), busy high for 5 cycles after the issue cycle.
    instr_class = 3'd7;
    n_start = 0; n_stall = 0; n_held = 0; ret_k = -1; start_k = -1;
    for (int k = 0; k < 10; k++) begin
      busy = (k >= 3 && k <= 7);
      #1;
      if (mdu_start) begin n_start++; start_k = k; end
      if (stall) n_stall++;
      if (phase == 6'h04 && !retire) n_held++;
      if (retire) ret_k = k;
      if (k < 9) step();
    end
    busy = 1'b0;
    chk("wait_mdu_pulses", 64'(n_start), 64'd1);
    chk("wait_mdu_cycle", 64'(start_k), 64'd2);
    chk("wait_stall_cycles", 64'(n_stall), 64'd5);
    chk("wait_p2_held", 64'(n_held), 64'd6);
    chk("wait_retire_cycle", 64'(ret_k), 64'd8);
    chk("wait_back_p0", 64'(phase), 64'h01);
    chk("wait_cnt", 64'(instr_cnt), 64'd2);

    // Class 3, L=3: exc_req and irq held from P0; ignored until last phase,
    // then exc_req wins with TEQ cause.
    #1;
    instr_class = 3'd3; exc_req = 1'b1; exc_code = 5'b01101; irq = 1'b1; irq_en = 1'b1;
    step(); #1;
    chk("exc_ignored_p1", 64'(phase), 64'h02);
    step(); #1;
    chk("exc_last_retire", 64'({last_phase, retire}), 64'b11);
    step(); #1;
    exc_req = 1'b0; irq = 1'b0; exc_code = 5'd0;
    chk("exc_state_outs", 64'({phase, exc_take, exc_cause}), {58'd0, 1'b1, 5'b01101});
    step(); #1;
    chk("exc_then_p0", 64'({phase, exc_take}), {57'd0, 6'h01, 1'b0});
    chk("exc_cause_hold", 64'(exc_cause), 64'b01101);
    chk("exc_cnt", 64'(instr_cnt), 64'd3);

    // Class 1, L=2: P1 is last; irq with enable gives cause 0.
    instr_class = 3'd1;
    step(); #1;
    irq = 1'b1; irq_en = 1'b1;
    #1;
    chk("irq_p1_last", 64'({phase, last_phase, retire}), {56'd0, 6'h02, 2'b11});
    step(); #1;
    irq = 1'b0;
    chk("irq_exc", 64'({exc_take, exc_cause}), {58'd0, 1'b1, 5'b00000});
    step(); #1;

    // Class 1 again with irq but enable low: straight back to P0.
    step(); #1;
    irq = 1'b1; irq_en = 1'b0;
    step(); #1;
    irq = 1'b0;
    chk("irq_masked", 64'({phase, exc_take}), {57'd0, 6'h01, 1'b0});
    chk("irq_masked_cnt", 64'(instr_cnt), 64'd5);

    // Class 5, L=0: reserved instruction trap at P1.
    instr_class = 3'd5;
    step(); #1;
    chk("ri_p1_last", 64'({phase, last_phase, retire}), {56'd0, 6'h02, 2'b11});
    step(); #1;
    chk("ri_exc", 64'({phase, exc_take, exc_cause}), {58'd0, 1'b1, 5'b01010});
    chk("ri_cnt", 64'(instr_cnt), 64'd6);
    step(); #1;
    chk("ri_then_p0", 64'(phase), 64'h01);

    // Class 2, L=5: reset pulse in P3.
    instr_class = 3'd2;
    step(); step(); step(); #1;
    chk("rst_p3_phase", 64'({phase, last_phase}), {57'd0, 6'h08, 1'b0});
    rst = 1'b1;
    step(); #1;
    rst = 1'b0;
    chk("rst_p3_outputs", 64'(all_outs()), 64'd0);
    step(); #1;
    chk("rst_p3_then_p0", 64'(phase), 64'h01);
    chk("rst_p3_cnt", 64'(instr_cnt), 64'd0);

    // Class 7 again: reset during the busy stall abandons the instruction.
    instr_class = 3'd7;
    step(); step(); #1;
    chk("rst_stall_issue", 64'(mdu_start), 64'd1);
    step();
    busy = 1'b1;
    #1;
    chk("rst_stall_stalled", 64'(stall), 64'd1);
    rst = 1'b1;
    step(); #1;
    rst = 1'b0;
    chk("rst_stall_outputs", 64'(all_outs()), 64'd0);
    busy = 1'b0;
    step(); #1;
    chk("rst_stall_p0", 64'({phase, mdu_start, retire}), {56'd0, 6'h01, 2'b00});
    chk("rst_stall_cnt", 64'(instr_cnt), 64'd0);

    // Counter wrap with class 1 (two cycles per instruction).
    instr_class = 3'd1;
    force dut.instr_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.instr_cnt_q;
    step(); #1;
    chk("wrap_p1_phase", 64'(phase), 64'h02);
    step(); #1;
    chk("wrap_cnt_max", 64'(instr_cnt), 64'hFFFF_FFFF);
    chk("wrap_p0_phase_a", 64'(phase), 64'h01);
    step(); #1;
    chk("wrap_p1_phase_b", 64'(phase), 64'h02);
    step(); #1;
    chk("wrap_cnt_zero", 64'(instr_cnt), 64'd0);
    chk("wrap_p0_phase_b", 64'({phase, exc_take}), {57'd0, 6'h01, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
